// File: rtl/fd_stage_buffer.sv
// fd_stage_buffer
// Fetch/decode pipeline buffer that assembles two-word instructions
// (instruction + 16-bit immediate) from a 16-bit fetch stream and carries
// interrupt requests forward until they can ride on an issued instruction.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   instr_in       word fetched this cycle (instruction or immediate)
//   PC_in          address of instr_in
//   interrupt      interrupt request pulse
//   stall          hold the buffer contents and outputs
//   flush          discard buffer contents (taken branch/jump)
//   instr_out      instruction presented to decode
//   imm_out        immediate belonging to instr_out (0 for one-word instrs)
//   PC_out         address of the first word of instr_out
//   valid_out      instr_out is a real instruction
//   interrupt_out  interrupt tag attached to the issued instruction
//   imm_pending    high while waiting for the immediate word
module fd_stage_buffer #(
  parameter logic [15:0] NOP_WORD     = 16'h0000,
  parameter int          IMM_FLAG_BIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [31:0] PC_in,
  input  logic        interrupt,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] imm_out,
  output logic [31:0] PC_out,
  output logic        valid_out,
  output logic        interrupt_out,
  output logic        imm_pending
);

  localparam logic [0:0] NORMAL   = 1'b0;
  localparam logic [0:0] WAIT_IMM = 1'b1;

  logic [0:0]  state;
  logic [15:0] hold_instr;
  logic [31:0] hold_pc;
  logic        int_pending;
  logic        issue;

  // An issue edge is one where valid_out is written 1: either the immediate
  // arrives for a held instruction, or a one-word instruction is fetched.
  always_comb begin
    issue = 1'b0;
    if (!rst && !flush && !stall) begin
      issue = (state == WAIT_IMM) || !instr_in[IMM_FLAG_BIT];
    end
  end

  // imm_pending is a pure decode of the state register, so it stays registered.
  assign imm_pending = (state == WAIT_IMM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= NORMAL;
      hold_instr    <= '0;
      hold_pc       <= '0;
      int_pending   <= 1'b0;
      instr_out     <= NOP_WORD;
      imm_out       <= '0;
      PC_out        <= '0;
      valid_out     <= 1'b0;
      interrupt_out <= 1'b0;
    end else begin
      // Requests are remembered through stalls and flushes until delivered.
      int_pending <= interrupt | (int_pending & ~issue);

      if (flush) begin
        state         <= NORMAL;
        hold_instr    <= '0;
        hold_pc       <= '0;
        instr_out     <= NOP_WORD;
        imm_out       <= '0;
        PC_out        <= PC_in;
        valid_out     <= 1'b0;
        interrupt_out <= 1'b0;
      end else if (!stall) begin
        if (state == WAIT_IMM) begin
          // Incoming word is the immediate, whatever its flag bit says.
          state         <= NORMAL;
          instr_out     <= hold_instr;
          imm_out       <= instr_in;
          PC_out        <= hold_pc;
          valid_out     <= 1'b1;
          interrupt_out <= int_pending | interrupt;
        end else if (instr_in[IMM_FLAG_BIT]) begin
          // First half of a two-word instruction: park it and emit a bubble.
          state         <= WAIT_IMM;
          hold_instr    <= instr_in;
          hold_pc       <= PC_in;
          instr_out     <= NOP_WORD;
          imm_out       <= '0;
          PC_out        <= PC_in;
          valid_out     <= 1'b0;
          interrupt_out <= 1'b0;
        end else begin
          instr_out     <= instr_in;
          imm_out       <= '0;
          PC_out        <= PC_in;
          valid_out     <= 1'b1;
          interrupt_out <= int_pending | interrupt;
        end
      end
    end
  end

endmodule

// File: doc/fd_stage_buffer.md
FD_STAGE_BUFFER -- requirements
Module: fd_stage_buffer

Interface
REQ-001 The parameter NOP_WORD SHALL default to 16'h0000 and SHALL be the instruction word driven during bubbles.
REQ-002 The parameter IMM_FLAG_BIT SHALL default to 15 and SHALL select the instr_in bit that marks a two-word (instruction + immediate) instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates SHALL occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 instr_in  input  16  SHALL carry the word fetched this cycle (an instruction or an immediate).
REQ-006 PC_in  input  32  SHALL carry the address of instr_in.
REQ-007 interrupt  input  1  SHALL be the interrupt request pulse from the interrupt pin.
REQ-008 stall  input  1  SHALL be the hazard-unit request to hold the buffer.
REQ-009 flush  input  1  SHALL be the request to discard buffer contents (taken branch/jump).
REQ-010 instr_out  output  16  SHALL be the instruction presented to decode.
REQ-011 imm_out  output  16  SHALL be the immediate belonging to instr_out, or 16'h0000 for one-word instructions.
REQ-012 PC_out  output  32  SHALL be the address of the first word of instr_out.
REQ-013 valid_out  output  1  SHALL be high when instr_out is a real instruction.
REQ-014 interrupt_out  output  1  SHALL be the interrupt tag attached to the issued instruction.
REQ-015 imm_pending  output  1  SHALL be high while the block is in WAIT_IMM.

Function
REQ-016 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-017 The FSM SHALL have exactly two states: NORMAL and WAIT_IMM.
REQ-018 Priority on each edge SHALL be rst > flush > stall > normal operation.
REQ-019 NORMAL with instr_in[IMM_FLAG_BIT]=0 SHALL issue next edge: instr_out=instr_in, imm_out=0, PC_out=PC_in, valid_out=1; the state SHALL remain NORMAL (latency 1 cycle).
REQ-020 NORMAL with instr_in[IMM_FLAG_BIT]=1 SHALL capture instr_in and PC_in into hold registers, drive a bubble (instr_out=NOP_WORD, imm_out=0, valid_out=0), and move to WAIT_IMM.
REQ-021 WAIT_IMM SHALL treat instr_in as the immediate regardless of its flag bit, issue instr_out=held instr, imm_out=instr_in, PC_out=held PC, valid_out=1, and return to NORMAL.
REQ-022 stall=1 SHALL hold state, hold registers and all outputs unchanged, except interrupt capture per REQ-025.
REQ-023 flush=1 SHALL drive a bubble (instr_out=NOP_WORD, imm_out=0, valid_out=0, interrupt_out=0), clear the hold registers, and force NORMAL, also when in WAIT_IMM; PC_out SHALL take PC_in.
REQ-024 An internal int_pending flag SHALL record interrupt requests until they are delivered.
REQ-025 On every non-reset edge, int_pending SHALL be set to interrupt | (int_pending & ~issue), where issue means valid_out is written 1 on that edge; stall and flush SHALL NOT lose a request.
REQ-026 On an issue edge, interrupt_out SHALL equal int_pending | interrupt; on every other non-stall edge it SHALL be 0.
REQ-027 The block SHALL NOT issue an interrupt tag on a bubble.

Reset
REQ-028 rst=1 SHALL force NORMAL, clear int_pending and the hold registers, and set instr_out=NOP_WORD, imm_out=0, PC_out=0, valid_out=0, interrupt_out=0 and imm_pending=0, overriding flush and stall.
REQ-029 rst asserted in WAIT_IMM SHALL discard the held instruction; the first word after reset SHALL be decoded as an instruction.

Verification
REQ-030 Sequence instr_in=16'h1234, PC_in=0x10 -> next edge: instr_out=16'h1234, PC_out=0x10, imm_out=0, valid_out=1.
REQ-031 Sequence 16'h8A01 @0x20, then 16'hBEEF @0x21 -> edge 1: valid_out=0, imm_pending=1; edge 2: instr_out=16'h8A01, imm_out=16'hBEEF, PC_out=0x20, valid_out=1.
REQ-032 Sequence 16'h8A01, then stall for 2 cycles, then 16'h0055 -> the outputs hold the bubble during the stall, then issue imm_out=16'h0055.
REQ-033 Sequence 16'h8A01, then flush=1 with 16'h0003 -> bubble, NORMAL; the next 16'h0003 is issued as a one-word instruction.
REQ-034 Interrupt pulse during a flush cycle, followed by 16'h0007 -> instr_out=16'h0007 with interrupt_out=1, after which int_pending=0.
REQ-035 rst asserted in WAIT_IMM together with flush and stall -> all outputs at their reset values, imm_pending=0.
